// File: rtl/log10_share_sched_if.sv
// Bundles the peak input, shared log10 engine link, paired result and status
// signals of log10_share_sched. slave is the scheduler side, master the environment.
interface log10_share_sched_if #(
    parameter int PEAK_W = 23,
    parameter int LOG_W  = 17,
    parameter int CNT_W  = 8
);
    logic              peak_valid;
    logic [PEAK_W-1:0] peak_left;
    logic [PEAK_W-1:0] peak_right;
    logic              eng_vin;
    logic [PEAK_W:0]   eng_din;
    logic              eng_vout;
    logic [LOG_W-1:0]  eng_dout;
    logic              log_valid;
    logic [LOG_W-1:0]  log_left;
    logic [LOG_W-1:0]  log_right;
    logic              busy;
    logic [CNT_W-1:0]  drop_cnt;
    logic              timeout_err;
    logic              stray_err;
    logic              err_clear;

    modport slave (
        input  peak_valid, peak_left, peak_right, eng_vout, eng_dout, err_clear,
        output eng_vin, eng_din, log_valid, log_left, log_right, busy,
               drop_cnt, timeout_err, stray_err
    );

    modport master (
        output peak_valid, peak_left, peak_right, eng_vout, eng_dout, err_clear,
        input  eng_vin, eng_din, log_valid, log_left, log_right, busy,
               drop_cnt, timeout_err, stray_err
    );
endinterface

// File: rtl/log10_share_sched.sv
// Shares one log10 engine between left and right peaks: issues left, then right,
// pairs the two results into one log_valid strobe and tracks drop/timeout/stray errors.
module log10_share_sched #(
    parameter int PEAK_W  = 23,
    parameter int LOG_W   = 17,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 aresetn,
    log10_share_sched_if.slave   bus
);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_L,
        S_WAIT_L,
        S_ISSUE_R,
        S_WAIT_R,
        S_EMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PEAK_W:0]    r_eng_din;
    logic [PEAK_W-1:0]  r_peak_right;
    logic [LOG_W-1:0]   r_cap_left;
    logic [LOG_W-1:0]   r_log_left;
    logic [LOG_W-1:0]   r_log_right;
    logic [TMR_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_timeout_err;
    logic               r_stray_err;

    logic               w_in_wait;
    logic               w_accept;
    logic               w_drop;
    logic               w_stray;
    logic               w_expired;
    logic               w_timeout;
    logic               w_eng_vin;
    logic               w_busy;
    logic               w_log_valid;

    always_comb begin
        w_state_next = r_state;
        w_eng_vin    = 1'b0;
        w_busy       = 1'b1;
        w_log_valid  = 1'b0;
        w_in_wait    = (r_state == S_WAIT_L) || (r_state == S_WAIT_R);
        // The last wait cycle is the one where the counter has reached TIMEOUT-2.
        w_expired    = (r_wait_cnt == TMR_W'(TIMEOUT - 2));
        w_timeout    = w_in_wait && !bus.eng_vout && w_expired;
        w_stray      = bus.eng_vout && !w_in_wait;
        case (r_state)
            S_IDLE, S_EMIT: begin
                w_busy       = 1'b0;
                w_log_valid  = (r_state == S_EMIT);
                w_state_next = bus.peak_valid ? S_ISSUE_L : S_IDLE;
            end
            S_ISSUE_L: begin
                w_eng_vin    = 1'b1;
                w_state_next = S_WAIT_L;
            end
            S_WAIT_L: begin
                if (bus.eng_vout)   w_state_next = S_ISSUE_R;
                else if (w_expired) w_state_next = S_IDLE;
            end
            S_ISSUE_R: begin
                w_eng_vin    = 1'b1;
                w_state_next = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (bus.eng_vout)   w_state_next = S_EMIT;
                else if (w_expired) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_accept = bus.peak_valid && !w_busy;
        w_drop   = bus.peak_valid && w_busy;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_eng_din    <= '0;
            r_peak_right <= '0;
            r_cap_left   <= '0;
            r_log_left   <= '0;
            r_log_right  <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_in_wait ? r_wait_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_eng_din    <= {bus.peak_left, 1'b0};
                r_peak_right <= bus.peak_right;
            end
            if ((r_state == S_WAIT_L) && bus.eng_vout) begin
                r_cap_left <= bus.eng_dout;
                r_eng_din  <= {r_peak_right, 1'b0};
            end
            // Both results move to the outputs together so the pair stays coherent.
            if ((r_state == S_WAIT_R) && bus.eng_vout) begin
                r_log_left  <= r_cap_left;
                r_log_right <= bus.eng_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_drop_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_stray_err   <= 1'b0;
        end else if (bus.err_clear) begin
            r_drop_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_stray_err   <= 1'b0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_timeout)                    r_timeout_err <= 1'b1;
            if (w_stray)                      r_stray_err   <= 1'b1;
        end
    end

    assign bus.eng_vin     = w_eng_vin;
    assign bus.eng_din     = r_eng_din;
    assign bus.log_valid   = w_log_valid;
    assign bus.log_left    = r_log_left;
    assign bus.log_right   = r_log_right;
    assign bus.busy        = w_busy;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.timeout_err = r_timeout_err;
    assign bus.stray_err   = r_stray_err;
endmodule

// File: tb/tb_log10_share_sched.sv
// Bench for log10_share_sched: a cycle-stamped transaction model checked every cycle,
// directed latency/overrun/timeout/tie/reset scenarios and a randomized run.
module tb_log10_share_sched;
    localparam int PW = 23;
    localparam int LW = 17;
    localparam int TO = 16;
    localparam int CW = 8;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    log10_share_sched_if #(.PEAK_W(PW), .LOG_W(LW), .CNT_W(CW)) bus ();

    log10_share_sched #(.PEAK_W(PW), .LOG_W(LW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Engine emulation: mode 0 fixed latency, 1 random latency, 2 never answers.
    int              dcyc = 0;
    int              g_mode = 0;
    int              g_lat = 4;
    bit              g_fixed = 1'b1;
    int              eng_due = -1;
    logic [LW-1:0]   eng_data = '0;

    task automatic tick(input bit pv, input bit clr, input bit stray);
        int l;
        @(posedge clk);
        #1;
        dcyc++;
        if (bus.eng_vin === 1'b1) begin
            if (g_mode == 0)      l = g_lat;
            else if (g_mode == 1) l = int'($urandom_range(TO + 2, 1));
            else                  l = -1;
            eng_due  = (l < 0) ? -1 : dcyc + l;
            if (g_fixed) eng_data = (bus.eng_din == 24'h800000) ? 17'h1F00A : 17'h00B55;
            else         eng_data = LW'($urandom);
        end
        bus.eng_vout   = stray || (eng_due == dcyc);
        bus.eng_dout   = (eng_due == dcyc) ? eng_data : LW'($urandom);
        if (eng_due == dcyc) eng_due = -1;
        bus.peak_valid = pv;
        bus.peak_left  = g_fixed ? 23'h400000 : PW'($urandom);
        bus.peak_right = g_fixed ? 23'h000001 : PW'($urandom);
        bus.err_clear  = clr;
    endtask

    // Model: a block is a pair of issue timestamps; results are stamped with the emit cycle.
    int            mcyc = 0;
    bit            m_act = 0, m_side = 0, m_terr = 0, m_serr = 0;
    int            m_issue_cyc = 0, m_emit_cyc = -10, m_drop = 0;
    logic [PW-1:0] m_pl = '0, m_pr = '0;
    logic [LW-1:0] m_cap = '0, m_ll = '0, m_lr = '0;
    bit            c_issue, c_wait, c_emit, c_act0;

    always @(negedge clk) begin
        if (!aresetn) begin
            chk("rst_eng_vin", bus.eng_vin, 0);
            chk("rst_eng_din", bus.eng_din, 0);
            chk("rst_log_valid", bus.log_valid, 0);
            chk("rst_log_left", bus.log_left, 0);
            chk("rst_log_right", bus.log_right, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_drop_cnt", bus.drop_cnt, 0);
            chk("rst_timeout_err", bus.timeout_err, 0);
            chk("rst_stray_err", bus.stray_err, 0);
            m_act = 0; m_side = 0; m_terr = 0; m_serr = 0; m_drop = 0;
            m_emit_cyc = -10; m_cap = '0; m_ll = '0; m_lr = '0;
        end else begin
            c_act0  = m_act;
            c_issue = m_act && (mcyc == m_issue_cyc);
            c_wait  = m_act && (mcyc > m_issue_cyc);
            c_emit  = (mcyc == m_emit_cyc);
            chk("eng_vin", bus.eng_vin, c_issue);
            chk("busy", bus.busy, m_act);
            chk("log_valid", bus.log_valid, c_emit);
            chk("log_left", bus.log_left, m_ll);
            chk("log_right", bus.log_right, m_lr);
            chk("drop_cnt", bus.drop_cnt, m_drop);
            chk("timeout_err", bus.timeout_err, m_terr);
            chk("stray_err", bus.stray_err, m_serr);
            if (m_act) chk("eng_din", bus.eng_din, m_side ? {m_pr, 1'b0} : {m_pl, 1'b0});

            if (bus.err_clear) begin
                m_drop = 0; m_terr = 0; m_serr = 0;
            end else begin
                if (bus.peak_valid && c_act0 && m_drop < DROP_MAX) m_drop++;
                if (bus.eng_vout && !c_wait) m_serr = 1;
            end
            if (c_wait && bus.eng_vout) begin
                if (!m_side) begin
                    m_cap = bus.eng_dout; m_side = 1; m_issue_cyc = mcyc + 1;
                end else begin
                    m_ll = m_cap; m_lr = bus.eng_dout; m_emit_cyc = mcyc + 1; m_act = 0;
                end
            end else if (c_wait && (mcyc - m_issue_cyc - 1 == TO - 2)) begin
                m_act = 0;
                if (!bus.err_clear) m_terr = 1;
            end
            if (bus.peak_valid && !c_act0) begin
                m_act = 1; m_side = 0; m_issue_cyc = mcyc + 1;
                m_pl = bus.peak_left; m_pr = bus.peak_right;
            end
        end
        mcyc++;
    end

    initial begin
        bus.peak_valid = 0; bus.peak_left = '0; bus.peak_right = '0;
        bus.eng_vout = 0; bus.eng_dout = '0; bus.err_clear = 0;
        @(posedge clk);
        #4;
        chk("lit_reset_busy", bus.busy, 0);
        chk("lit_reset_drop", bus.drop_cnt, 0);
        @(posedge clk);
        #1 aresetn = 1'b1;

        // Single block, L=4
        tick(1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(0, 0, 0);
            #3;
            if (k == 1) begin
                chk("lit_vin_c1", bus.eng_vin, 1);
                chk("lit_din_left", bus.eng_din, 24'h800000);
            end else if (k == 6) begin
                chk("lit_vin_c6", bus.eng_vin, 1);
                chk("lit_din_right", bus.eng_din, 24'h000002);
            end else if (k == 11) begin
                chk("lit_log_valid_c11", bus.log_valid, 1);
                chk("lit_log_left", bus.log_left, 17'h1F00A);
                chk("lit_log_right", bus.log_right, 17'h00B55);
            end else begin
                chk("lit_vin_idle", bus.eng_vin, 0);
                chk("lit_log_valid_idle", bus.log_valid, 0);
            end
        end

        // Back-to-back: new block accepted in EMIT
        tick(1, 0, 0);
        for (int k = 1; k <= 23; k++) begin
            tick(k == 11, 0, 0);
            #3;
            chk("lit_b2b_log_valid", bus.log_valid, (k == 11 || k == 22) ? 1 : 0);
        end
        chk("lit_b2b_no_drop", bus.drop_cnt, 0);

        // Overrun in cycle 3
        tick(1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(k == 3, 0, 0);
            #3;
            if (k == 11) begin
                chk("lit_ovr_log_valid", bus.log_valid, 1);
                chk("lit_ovr_log_left", bus.log_left, 17'h1F00A);
                chk("lit_ovr_log_right", bus.log_right, 17'h00B55);
            end
        end
        chk("lit_ovr_drop1", bus.drop_cnt, 1);

        // Saturating drops
        repeat (400) tick(1, 0, 0);
        #3;
        chk("lit_drop_sat", bus.drop_cnt, 8'hFF);
        repeat (12) tick(0, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        #3;
        chk("lit_drop_cleared", bus.drop_cnt, 0);

        // Timeout, then late result
        g_mode = 2;
        tick(1, 0, 0);
        for (int k = 1; k <= TO + 3; k++) begin
            tick(0, 0, 0);
            #3;
            chk("lit_to_no_log_valid", bus.log_valid, 0);
            if (k == TO) begin
                chk("lit_to_err_before", bus.timeout_err, 0);
                chk("lit_to_busy_before", bus.busy, 1);
            end else if (k == TO + 1) begin
                chk("lit_to_err_set", bus.timeout_err, 1);
                chk("lit_to_busy_after", bus.busy, 0);
            end
        end
        tick(0, 0, 1);
        tick(0, 0, 0);
        #3;
        chk("lit_late_stray", bus.stray_err, 1);
        tick(0, 1, 0);
        tick(0, 0, 0);
        #3;
        chk("lit_clear_stray", bus.stray_err, 0);
        chk("lit_clear_timeout", bus.timeout_err, 0);

        // Tie: result arrives on the timeout cycle
        g_mode = 0;
        g_lat = TO - 1;
        tick(1, 0, 0);
        for (int k = 1; k <= 3 + 2 * (TO - 1) + 1; k++) begin
            tick(0, 0, 0);
            #3;
            if (k == 3 + 2 * (TO - 1)) begin
                chk("lit_tie_log_valid", bus.log_valid, 1);
                chk("lit_tie_log_left", bus.log_left, 17'h1F00A);
            end
        end
        chk("lit_tie_no_timeout", bus.timeout_err, 0);

        // Reset while waiting for the right result
        g_lat = 4;
        tick(1, 0, 0);
        for (int k = 1; k <= 8; k++) tick(0, 0, 0);
        aresetn = 1'b0;
        #3;
        chk("lit_rst_busy", bus.busy, 0);
        chk("lit_rst_din", bus.eng_din, 0);
        chk("lit_rst_log_left", bus.log_left, 0);
        tick(0, 0, 0);
        aresetn = 1'b1;
        eng_due = -1;
        tick(1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(0, 0, 0);
            #3;
            if (k == 11) begin
                chk("lit_post_rst_log_valid", bus.log_valid, 1);
                chk("lit_post_rst_log_right", bus.log_right, 17'h00B55);
            end
        end
        chk("lit_post_rst_stray", bus.stray_err, 0);

        // Randomized traffic, latencies spanning the timeout limit
        g_fixed = 1'b0;
        g_mode = 1;
        repeat (3000) tick($urandom_range(7, 0) == 0, $urandom_range(49, 0) == 0,
                           $urandom_range(63, 0) == 0);
        repeat (40) tick(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
